// File: rtl/dmem_lsu_pkg.sv
// Shared types, constants and helpers for the data-memory load/store sequencer.
package dmem_lsu_pkg;

  localparam int unsigned WORD_BYTES = 4;
  localparam logic [3:0]  WE_NONE_L  = 4'hF;

  typedef enum logic [1:0] {IDLE, ACC1, ACC2, RESP} lsu_state_t;
  typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} lsu_size_t;

  // Registered request payload (word address is kept separately, its width is a parameter)
  typedef struct packed {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [1:0]  off;
    logic [31:0] wdata;
  } lsu_req_t;

  // Access length in bytes; 0 for the illegal size code
  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    logic [2:0] n;
    case (size)
      SZ_BYTE: n = 3'd1;
      SZ_HALF: n = 3'd2;
      SZ_WORD: n = 3'd4;
      default: n = 3'd0;
    endcase
    return n;
  endfunction

  // Byte-lane enables across two consecutive words: [3:0] first word, [7:4] second word
  function automatic logic [7:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
    logic [7:0] m;
    case (size)
      SZ_BYTE: m = 8'h01;
      SZ_HALF: m = 8'h03;
      SZ_WORD: m = 8'h0F;
      default: m = 8'h00;
    endcase
    return m << off;
  endfunction

  // Access spills into the next word
  function automatic logic is_cross(input logic [1:0] size, input logic [1:0] off);
    return (4'(off) + 4'(size_bytes(size))) > 4'(WORD_BYTES);
  endfunction

  function automatic logic is_illegal(input logic [1:0] size);
    return size == 2'd3;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load alignment: extracts n bytes at offset o from {hi_word, lo_word} and extends them.
module lsu_load_align
  import dmem_lsu_pkg::*;
(
  input  logic [31:0] i_hi_word,
  input  logic [31:0] i_lo_word,
  input  logic [1:0]  i_off,
  input  logic [2:0]  i_nbytes,
  input  logic        i_unsigned,
  output logic [31:0] o_rdata_c
);

  logic [63:0] w_dword;
  logic [31:0] w_shift;

  assign w_dword = {i_hi_word, i_lo_word};
  assign w_shift = 32'(w_dword >> {i_off, 3'b000});

  // Mask to the access width, then sign- or zero-extend
  always_comb begin
    o_rdata_c = w_shift;
    case (i_nbytes)
      3'd1: o_rdata_c = i_unsigned ? {24'h0, w_shift[7:0]}
                                   : {{24{w_shift[7]}}, w_shift[7:0]};
      3'd2: o_rdata_c = i_unsigned ? {16'h0, w_shift[15:0]}
                                   : {{16{w_shift[15]}}, w_shift[15:0]};
      default: o_rdata_c = w_shift;
    endcase
  end

endmodule

// File: rtl/dmem_lsu_ctrl.sv
// Load/store sequencer between the memory stage and a word-organised data memory.
// Word-crossing accesses take two memory cycles (ACC1, ACC2).
// Build option: LSU_MISALIGN_TRAP_EN turns crossing accesses into error responses
// with no memory cycle instead of splitting them.
module dmem_lsu_ctrl
  import dmem_lsu_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                    clock,
  input  logic                    reset_L,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [1:0]              req_size,
  input  logic                    req_unsigned,
  input  logic [ADDR_WIDTH+1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  output logic                    rsp_valid,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [3:0]              mem_WE_L,
  input  logic [DATA_WIDTH-1:0]   mem_rdata
);

  lsu_state_t            r_state, w_state_nxt;
  lsu_req_t              r_req;
  logic [ADDR_WIDTH-1:0] r_waddr;
  logic [31:0]           r_lo, r_hi;

  logic                  r_req_ready, r_rsp_valid, r_rsp_err;
  logic [31:0]           r_rsp_rdata;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [31:0]           r_mem_wdata;
  logic [3:0]            r_mem_we_l;

  logic                  w_rsp_valid_nxt, w_rsp_err_nxt, w_req_ready_nxt;
  logic [31:0]           w_rsp_rdata_nxt;
  logic [ADDR_WIDTH-1:0] w_mem_addr_nxt;
  logic [31:0]           w_mem_wdata_nxt;
  logic [3:0]            w_mem_we_l_nxt;

  logic                  w_accept;
  logic                  w_in_bad, w_r_bad, w_r_cross;
  logic [ADDR_WIDTH-1:0] w_in_waddr;
  logic [63:0]           w_in_wide, w_r_wide;
  logic [7:0]            w_in_lanes, w_r_lanes;
  logic [2:0]            w_nbytes;
  logic [31:0]           w_align_c;

  assign w_accept   = req_valid && r_req_ready;
  assign w_in_waddr = req_addr[ADDR_WIDTH+1:2];
  assign w_in_wide  = 64'(req_wdata) << {req_addr[1:0], 3'b000};
  assign w_in_lanes = lane_mask(req_size, req_addr[1:0]);
  assign w_r_wide   = 64'(r_req.wdata) << {r_req.off, 3'b000};
  assign w_r_lanes  = lane_mask(r_req.size, r_req.off);
  assign w_r_cross  = is_cross(r_req.size, r_req.off);
  assign w_nbytes   = size_bytes(r_req.size);

`ifdef LSU_MISALIGN_TRAP_EN
  assign w_in_bad = is_illegal(req_size) || is_cross(req_size, req_addr[1:0]);
  assign w_r_bad  = is_illegal(r_req.size) || w_r_cross;
`else
  assign w_in_bad = is_illegal(req_size);
  assign w_r_bad  = is_illegal(r_req.size);
`endif

  lsu_load_align u_load_align (
    .i_hi_word  (r_hi),
    .i_lo_word  (r_lo),
    .i_off      (r_req.off),
    .i_nbytes   (w_nbytes),
    .i_unsigned (r_req.uns),
    .o_rdata_c  (w_align_c)
  );

  // Next state plus next values of every registered output
  always_comb begin
    w_state_nxt     = r_state;
    w_mem_addr_nxt  = r_mem_addr;
    w_mem_wdata_nxt = r_mem_wdata;
    w_mem_we_l_nxt  = WE_NONE_L;
    w_rsp_valid_nxt = 1'b0;
    w_rsp_rdata_nxt = r_rsp_rdata;
    w_rsp_err_nxt   = r_rsp_err;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (w_in_bad) begin
            w_state_nxt = RESP;
          end else begin
            w_state_nxt    = ACC1;
            w_mem_addr_nxt = w_in_waddr;
            if (req_we) begin
              w_mem_wdata_nxt = w_in_wide[31:0];
              w_mem_we_l_nxt  = ~w_in_lanes[3:0];
            end
          end
        end
      end
      ACC1: begin
`ifdef LSU_MISALIGN_TRAP_EN
        w_state_nxt = RESP;
`else
        if (w_r_cross) begin
          w_state_nxt    = ACC2;
          w_mem_addr_nxt = r_waddr + ADDR_WIDTH'(1);
          if (r_req.we) begin
            w_mem_wdata_nxt = w_r_wide[63:32];
            w_mem_we_l_nxt  = ~w_r_lanes[7:4];
          end
        end else begin
          w_state_nxt = RESP;
        end
`endif
      end
      RESP: begin
        w_state_nxt     = IDLE;
        w_rsp_valid_nxt = 1'b1;
        w_rsp_err_nxt   = w_r_bad;
        w_rsp_rdata_nxt = (r_req.we || w_r_bad) ? 32'h0 : w_align_c;
      end
      default: begin
        w_state_nxt = RESP;
      end
    endcase
  end

  assign w_req_ready_nxt = (w_state_nxt == IDLE);

  // State and output registers
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      r_state     <= IDLE;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_we_l  <= WE_NONE_L;
    end else begin
      r_state     <= w_state_nxt;
      r_req_ready <= w_req_ready_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_rdata <= w_rsp_rdata_nxt;
      r_rsp_err   <= w_rsp_err_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_wdata <= w_mem_wdata_nxt;
      r_mem_we_l  <= w_mem_we_l_nxt;
    end
  end

  // Request capture and load-word capture
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      r_req   <= '0;
      r_waddr <= '0;
      r_lo    <= '0;
      r_hi    <= '0;
    end else begin
      if (w_accept) begin
        r_req.we    <= req_we;
        r_req.size  <= req_size;
        r_req.uns   <= req_unsigned;
        r_req.off   <= req_addr[1:0];
        r_req.wdata <= req_wdata;
        r_waddr     <= w_in_waddr;
        r_hi        <= '0;
      end
      if (r_state == ACC1) r_lo <= mem_rdata;
      if (r_state == ACC2) r_hi <= mem_rdata;
    end
  end

  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_WE_L  = r_mem_we_l;

endmodule

// File: tb/tb_dmem_lsu_ctrl.sv
// Self-checking bench for dmem_lsu_ctrl: directed scenarios plus random traffic
// against a byte-addressed reference memory.
module tb_dmem_lsu_ctrl;

  localparam int unsigned AW     = 12;
  localparam int unsigned NWORDS = 1 << AW;
  localparam int unsigned NBYTES = 4 * NWORDS;

  logic          clock = 1'b0;
  logic          reset_L;
  logic          req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]    req_size;
  logic [AW+1:0] req_addr;
  logic [31:0]   req_wdata;
  logic          rsp_valid, rsp_err;
  logic [31:0]   rsp_rdata;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata, mem_rdata;
  logic [3:0]    mem_WE_L;

  dmem_lsu_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) dut (
    .clock(clock), .reset_L(reset_L),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_WE_L(mem_WE_L), .mem_rdata(mem_rdata)
  );

  always #5 clock = ~clock;

  // Data memory: combinational read, byte-lane write on the rising edge
  logic [31:0] mem [NWORDS];
  assign mem_rdata = mem[mem_addr];
  always @(posedge clock)
    for (int k = 0; k < 4; k++)
      if (!mem_WE_L[k]) mem[mem_addr][8*k +: 8] <= mem_wdata[8*k +: 8];

  // Trace of write cycles seen on the memory bus
  logic [AW-1:0] tr_addr[$];
  logic [3:0]    tr_we[$];
  logic [31:0]   tr_data[$];
  always @(negedge clock)
    if (mem_WE_L !== 4'hF) begin
      tr_addr.push_back(mem_addr);
      tr_we.push_back(mem_WE_L);
      tr_data.push_back(mem_wdata);
    end

  logic [7:0] ref_mem [NBYTES];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic int unsigned nb(input logic [1:0] size);
    return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
  endfunction

  function automatic bit crosses(input int unsigned addr, input logic [1:0] size);
    return (addr % 4) + nb(size) > 4;
  endfunction

  function automatic bit bad_req(input int unsigned addr, input logic [1:0] size);
`ifdef LSU_MISALIGN_TRAP_EN
    return size == 2'd3 || crosses(addr, size);
`else
    return size == 2'd3;
`endif
  endfunction

  function automatic logic [31:0] ref_load(input int unsigned addr, input logic [1:0] size,
                                           input bit uns);
    logic [31:0] v = '0;
    int unsigned n = nb(size);
    for (int i = 0; i < int'(n); i++) v[8*i +: 8] = ref_mem[(addr + i) % NBYTES];
    if (n < 4 && !uns && v[8*n-1])
      for (int i = int'(n); i < 4; i++) v[8*i +: 8] = 8'hFF;
    return v;
  endfunction

  task automatic ref_store(input int unsigned addr, input logic [1:0] size,
                           input logic [31:0] data, input int unsigned limit);
    for (int i = 0; i < int'(nb(size)) && i < int'(limit); i++)
      ref_mem[(addr + i) % NBYTES] = data[8*i +: 8];
  endtask

  // Issue one request at a falling edge; wait (bounded) for its response
  task automatic run_req(input bit we, input logic [1:0] size, input bit uns,
                         input logic [AW+1:0] addr, input logic [31:0] wdata,
                         output logic [31:0] rdata, output logic err, output int lat);
    chk("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    lat = -1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clock);
      req_valid = 1'b0;
      if (rsp_valid) begin lat = c; break; end
    end
    rdata = rsp_rdata;
    err   = rsp_err;
    @(negedge clock);
    chk("rsp_single_pulse", 32'(rsp_valid), 32'd0);
  endtask

  // Request checked against the reference model; reference updated for stores
  task automatic do_check(input string tag, input bit we, input logic [1:0] size, input bit uns,
                          input logic [AW+1:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata);
    bit          bad = bad_req(addr, size);
    int          exp_lat = bad ? 2 : (crosses(addr, size) ? 4 : 3);
    logic [31:0] exp_rd = (we || bad) ? 32'h0 : ref_load(addr, size, uns);
    logic        err;
    int          lat;
    run_req(we, size, uns, addr, wdata, rdata, err, lat);
    chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_err"}, 32'(err), 32'(bad));
    chk({tag, "_rdata"}, rdata, exp_rd);
    if (we && !bad) ref_store(addr, size, wdata, 4);
  endtask

  task automatic tr_clear();
    tr_addr.delete(); tr_we.delete(); tr_data.delete();
  endtask

  logic [31:0] rd;
  logic [AW+1:0] ra;
  logic [1:0] rs;
  bit seen;

  initial begin
    reset_L = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
    req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
    for (int i = 0; i < int'(NWORDS); i++) begin
      mem[i] = $urandom;
      for (int k = 0; k < 4; k++) ref_mem[4*i + k] = mem[i][8*k +: 8];
    end
    #2 reset_L = 1'b0;
    repeat (2) @(negedge clock);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    chk("rst_rsp_err",   32'(rsp_err), 32'd0);
    chk("rst_we_l",      32'(mem_WE_L), 32'hF);
    chk("rst_mem_addr",  32'(mem_addr), 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    reset_L = 1'b1;
    @(negedge clock);

    // Aligned word store then load
    tr_clear();
    do_check("s1_st", 1'b1, 2'd2, 1'b0, 14'h010, 32'hDEADBEEF, rd);
    chk("s1_wr_count", 32'(tr_addr.size()), 32'd1);
    if (tr_addr.size() == 1) begin
      chk("s1_wr_addr", 32'(tr_addr[0]), 32'h004);
      chk("s1_wr_we",   32'(tr_we[0]), 32'h0);
      chk("s1_wr_data", tr_data[0], 32'hDEADBEEF);
    end
    tr_clear();
    do_check("s1_ld", 1'b0, 2'd2, 1'b0, 14'h010, 32'h0, rd);
    chk("s1_ld_val", rd, 32'hDEADBEEF);
    chk("s1_ld_no_write", 32'(tr_addr.size()), 32'd0);

    // Byte store in the top lane, signed and unsigned loads
    tr_clear();
    do_check("s2_st", 1'b1, 2'd0, 1'b0, 14'h013, 32'h00000080, rd);
    chk("s2_wr_count", 32'(tr_addr.size()), 32'd1);
    if (tr_addr.size() == 1) begin
      chk("s2_wr_we",   32'(tr_we[0]), 32'h7);
      chk("s2_wr_data", tr_data[0], 32'h80000000);
    end
    do_check("s2_lds", 1'b0, 2'd0, 1'b0, 14'h013, 32'h0, rd);
    chk("s2_lds_val", rd, 32'hFFFFFF80);
    do_check("s2_ldu", 1'b0, 2'd0, 1'b1, 14'h013, 32'h0, rd);
    chk("s2_ldu_val", rd, 32'h00000080);

    // Word store crossing a word boundary
    tr_clear();
    do_check("s3_st", 1'b1, 2'd2, 1'b0, 14'h022, 32'h11223344, rd);
`ifdef LSU_MISALIGN_TRAP_EN
    chk("s3_trap_no_write", 32'(tr_addr.size()), 32'd0);
    do_check("s3_ld", 1'b0, 2'd2, 1'b0, 14'h022, 32'h0, rd);
`else
    chk("s3_wr_count", 32'(tr_addr.size()), 32'd2);
    if (tr_addr.size() == 2) begin
      chk("s3_acc1_addr", 32'(tr_addr[0]), 32'h008);
      chk("s3_acc1_we",   32'(tr_we[0]), 32'h3);
      chk("s3_acc1_data", tr_data[0], 32'h33440000);
      chk("s3_acc2_addr", 32'(tr_addr[1]), 32'h009);
      chk("s3_acc2_we",   32'(tr_we[1]), 32'hC);
      chk("s3_acc2_data", tr_data[1], 32'h00001122);
    end
    do_check("s3_ld", 1'b0, 2'd2, 1'b0, 14'h022, 32'h0, rd);
    chk("s3_ld_val", rd, 32'h11223344);
`endif

    // Half load at the last byte wraps to word 0
    do_check("s4_st_hi", 1'b1, 2'd0, 1'b0, 14'h3FFF, 32'h000000A5, rd);
    do_check("s4_st_lo", 1'b1, 2'd0, 1'b0, 14'h0000, 32'h0000005A, rd);
    do_check("s4_ld", 1'b0, 2'd1, 1'b1, 14'h3FFF, 32'h0, rd);
`ifndef LSU_MISALIGN_TRAP_EN
    chk("s4_ld_val", rd, 32'h00005AA5);
    chk("s4_wrap_addr", 32'(mem_addr), 32'h000);
`endif

    // Illegal size: error, no write activity
    tr_clear();
    do_check("s5_st", 1'b1, 2'd3, 1'b0, 14'h040, 32'hFFFFFFFF, rd);
    chk("s5_no_write", 32'(tr_addr.size()), 32'd0);

`ifndef LSU_MISALIGN_TRAP_EN
    // Reset between the two halves of a split store
    chk("s6_ready", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_unsigned = 1'b0;
    req_addr = 14'h022; req_wdata = 32'hCAFEF00D;
    @(negedge clock);
    req_valid = 1'b0;
    @(negedge clock);
    reset_L = 1'b0;
    #1;
    chk("s6_rst_we_l",  32'(mem_WE_L), 32'hF);
    chk("s6_rst_ready", 32'(req_ready), 32'd1);
    @(negedge clock);
    reset_L = 1'b1;
    ref_store(32'h022, 2'd2, 32'hCAFEF00D, 2);
    seen = 1'b0;
    repeat (6) begin
      @(negedge clock);
      if (rsp_valid) seen = 1'b1;
    end
    chk("s6_no_response", 32'(seen), 32'd0);
    do_check("s6_ld_lo", 1'b0, 2'd2, 1'b0, 14'h020, 32'h0, rd);
    do_check("s6_ld_hi", 1'b0, 2'd2, 1'b0, 14'h024, 32'h0, rd);
`endif

    // Random traffic concentrated on a small window plus the top of memory
    for (int it = 0; it < 400; it++) begin
      if ($urandom_range(0, 9) == 0) ra = 14'(NBYTES - 4 + $urandom_range(0, 3));
      else                           ra = 14'($urandom_range(0, 47));
      rs = ($urandom_range(0, 19) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      do_check("rnd", 1'($urandom_range(0, 1)), rs, 1'($urandom_range(0, 1)),
               ra, $urandom, rd);
    end

    // Final memory contents in the touched regions
    for (int w = 0; w < 16; w++)
      chk("final_mem", mem[w], {ref_mem[4*w+3], ref_mem[4*w+2], ref_mem[4*w+1], ref_mem[4*w]});
    chk("final_mem_top", mem[NWORDS-1],
        {ref_mem[NBYTES-1], ref_mem[NBYTES-2], ref_mem[NBYTES-3], ref_mem[NBYTES-4]});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
